// File: rtl/judge_ctrl.sv
// Judgement stage: debounces the two track buttons, grades each press against
// lcd_ctrl's note position, and keeps score, combo, life and game-over state.
module judge_ctrl #(
    parameter int DEBOUNCE_MS = 10,
    parameter int PERFECT_PTS = 100,
    parameter int NORMAL_PTS  = 50,
    parameter int LIFE_INIT   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tick,
    input  logic        i_btn_t1,
    input  logic        i_btn_t2,
    input  logic        i_game_start,
    input  logic        i_hit_t1,
    input  logic        i_pre_hit_t1,
    input  logic        i_hit_t2,
    input  logic        i_pre_hit_t2,
    input  logic        i_miss_t1,
    input  logic        i_miss_t2,
    output logic        o_clear_t1_perf,
    output logic        o_clear_t1_norm,
    output logic        o_clear_t2_perf,
    output logic        o_clear_t2_norm,
    output logic [1:0]  o_judge_t1,
    output logic [1:0]  o_judge_t2,
    output logic [15:0] o_score,
    output logic [7:0]  o_combo,
    output logic [7:0]  o_max_combo,
    output logic [3:0]  o_life,
    output logic        o_game_over
);

    localparam int CW = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    localparam logic [1:0] J_PERF = 2'd1;
    localparam logic [1:0] J_NORM = 2'd2;
    localparam logic [1:0] J_BAD  = 2'd3;

    logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]         stable_q, stable_d, press_q, press_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;

    logic [1:0]         state_q, state_d;
    logic [15:0]        score_q, score_d;
    logic [7:0]         combo_q, combo_d, max_q, max_d;
    logic [3:0]         life_q, life_d;
    logic [1:0][1:0]    judge_q, judge_d;
    logic [1:0]         clr_perf_q, clr_perf_d, clr_norm_q, clr_norm_d;

    logic [1:0]         miss_v, hit_v, pre_v;
    logic [1:0]         r_miss, r_perf, r_norm, r_empty;
    logic               active;
    logic [31:0]        pts, score_sum;
    logic [8:0]         combo_sum;
    logic [3:0]         n_miss;

    assign miss_v = {i_miss_t2, i_miss_t1};
    assign hit_v  = {i_hit_t2, i_hit_t1};
    assign pre_v  = {i_pre_hit_t2, i_pre_hit_t1};

    always_comb begin
        sync1_d  = {i_btn_t2, i_btn_t1};
        sync2_d  = sync1_q;
        stable_d = stable_q;
        press_d  = '0;
        cnt_d    = cnt_q;
        for (int unsigned t = 0; t < 2; t++) begin
            if (sync2_q[t] == stable_q[t]) begin
                cnt_d[t] = '0;
            end else if (i_tick) begin
                if (cnt_q[t] == CW'(DEBOUNCE_MS - 1)) begin
                    stable_d[t] = sync2_q[t];
                    press_d[t]  = sync2_q[t];
                    cnt_d[t]    = '0;
                end else begin
                    cnt_d[t] = cnt_q[t] + CW'(1);
                end
            end
        end
    end

    // Judging stops the cycle life hits zero so nothing lands while OVER is pending.
    always_comb begin
        active  = (state_q == S_PLAY) && i_game_start && (life_q != '0);
        r_miss  = '0;
        r_perf  = '0;
        r_norm  = '0;
        r_empty = '0;
        for (int unsigned t = 0; t < 2; t++) begin
            if (active) begin
                if (miss_v[t])      r_miss[t]  = 1'b1;
                else if (press_q[t]) begin
                    if (hit_v[t])      r_perf[t]  = 1'b1;
                    else if (pre_v[t]) r_norm[t]  = 1'b1;
                    else               r_empty[t] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pts = (r_perf[0] ? 32'(PERFECT_PTS) : '0) + (r_perf[1] ? 32'(PERFECT_PTS) : '0)
            + (r_norm[0] ? 32'(NORMAL_PTS)  : '0) + (r_norm[1] ? 32'(NORMAL_PTS)  : '0);
        score_sum = 32'(score_q) + pts;
        score_d   = (score_sum > 32'hFFFF) ? 16'hFFFF : score_sum[15:0];

        combo_sum = 9'(combo_q) + 9'(r_perf[0] | r_norm[0]) + 9'(r_perf[1] | r_norm[1]);
        if ((r_miss | r_empty) != '0) combo_d = '0;
        else                          combo_d = combo_sum[8] ? 8'hFF : combo_sum[7:0];
        max_d = (combo_d > max_q) ? combo_d : max_q;

        n_miss = 4'(r_miss[0]) + 4'(r_miss[1]);
        life_d = (life_q > n_miss) ? life_q - n_miss : '0;

        judge_d    = judge_q;
        clr_perf_d = r_perf;
        clr_norm_d = r_norm;
        for (int unsigned t = 0; t < 2; t++) begin
            if (r_miss[t] || r_empty[t]) judge_d[t] = J_BAD;
            else if (r_perf[t])          judge_d[t] = J_PERF;
            else if (r_norm[t])          judge_d[t] = J_NORM;
        end

        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_game_start) begin
                state_d = S_PLAY;
                score_d = '0;
                combo_d = '0;
                max_d   = '0;
                judge_d = '0;
                life_d  = 4'(LIFE_INIT);
            end
            S_PLAY: begin
                if (!i_game_start)      state_d = S_IDLE;
                else if (life_q == '0)  state_d = S_OVER;
            end
            S_OVER: if (!i_game_start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            press_q    <= '0;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            score_q    <= '0;
            combo_q    <= '0;
            max_q      <= '0;
            life_q     <= 4'(LIFE_INIT);
            judge_q    <= '0;
            clr_perf_q <= '0;
            clr_norm_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            press_q    <= press_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            score_q    <= score_d;
            combo_q    <= combo_d;
            max_q      <= max_d;
            life_q     <= life_d;
            judge_q    <= judge_d;
            clr_perf_q <= clr_perf_d;
            clr_norm_q <= clr_norm_d;
        end
    end

    assign o_clear_t1_perf = clr_perf_q[0];
    assign o_clear_t2_perf = clr_perf_q[1];
    assign o_clear_t1_norm = clr_norm_q[0];
    assign o_clear_t2_norm = clr_norm_q[1];
    assign o_judge_t1      = judge_q[0];
    assign o_judge_t2      = judge_q[1];
    assign o_score         = score_q;
    assign o_combo         = combo_q;
    assign o_max_combo     = max_q;
    assign o_life          = life_q;
    assign o_game_over     = (state_q == S_OVER);

endmodule

// File: tb/tb_judge_ctrl.sv
// Bench for judge_ctrl: scenario tasks plus randomized presses, checked against
// a score/combo/life model kept in plain integer arithmetic.
module tb_judge_ctrl;

    logic        clk = 1'b0;
    logic        rst, i_tick, i_btn_t1, i_btn_t2, i_game_start;
    logic        i_hit_t1, i_pre_hit_t1, i_hit_t2, i_pre_hit_t2, i_miss_t1, i_miss_t2;
    logic        o_clear_t1_perf, o_clear_t1_norm, o_clear_t2_perf, o_clear_t2_norm;
    logic [1:0]  o_judge_t1, o_judge_t2;
    logic [15:0] o_score;
    logic [7:0]  o_combo, o_max_combo;
    logic [3:0]  o_life;
    logic        o_game_over;

    judge_ctrl #(.DEBOUNCE_MS(2), .PERFECT_PTS(100), .NORMAL_PTS(50), .LIFE_INIT(5)) dut (
        .clk(clk), .rst(rst), .i_tick(i_tick), .i_btn_t1(i_btn_t1), .i_btn_t2(i_btn_t2),
        .i_game_start(i_game_start), .i_hit_t1(i_hit_t1), .i_pre_hit_t1(i_pre_hit_t1),
        .i_hit_t2(i_hit_t2), .i_pre_hit_t2(i_pre_hit_t2), .i_miss_t1(i_miss_t1), .i_miss_t2(i_miss_t2),
        .o_clear_t1_perf(o_clear_t1_perf), .o_clear_t1_norm(o_clear_t1_norm),
        .o_clear_t2_perf(o_clear_t2_perf), .o_clear_t2_norm(o_clear_t2_norm),
        .o_judge_t1(o_judge_t1), .o_judge_t2(o_judge_t2), .o_score(o_score), .o_combo(o_combo),
        .o_max_combo(o_max_combo), .o_life(o_life), .o_game_over(o_game_over)
    );

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 1 ms strobe stand-in: one cycle in every four.
    always @(negedge clk) i_tick = (cyc % 4 == 0);

    int n_cmp = 0, n_err = 0;
    int n_p1 = 0, n_n1 = 0, n_p2 = 0, n_n2 = 0, n_both = 0, n_wide = 0;
    int unsigned last_p1_cyc = 0;
    logic [3:0] prev_clr = '0;

    always @(negedge clk) begin
        if (o_clear_t1_perf === 1'b1) begin n_p1++; last_p1_cyc = cyc; end
        if (o_clear_t1_norm === 1'b1) n_n1++;
        if (o_clear_t2_perf === 1'b1) n_p2++;
        if (o_clear_t2_norm === 1'b1) n_n2++;
        if (o_clear_t1_perf === 1'b1 && o_clear_t2_perf === 1'b1) n_both++;
        if (({o_clear_t1_perf, o_clear_t1_norm, o_clear_t2_perf, o_clear_t2_norm} & prev_clr) != '0) n_wide++;
        prev_clr = {o_clear_t1_perf, o_clear_t1_norm, o_clear_t2_perf, o_clear_t2_norm};
    end

    logic [40:0] dut_v;
    assign dut_v = {o_score, o_combo, o_max_combo, o_life, o_judge_t1, o_judge_t2, o_game_over};

    // Reference model: results 0 none, 1 perfect, 2 normal, 3 miss, 4 empty.
    int m_score, m_combo, m_max, m_life, m_j1, m_j2;
    bit m_over;
    int e_p1 = 0, e_n1 = 0, e_p2 = 0, e_n2 = 0;
    int lat = 10;

    function automatic void m_start();
        m_score = 0; m_combo = 0; m_max = 0; m_life = 5; m_j1 = 0; m_j2 = 0; m_over = 0;
    endfunction

    function automatic int m_code(int r);
        return (r == 1) ? 1 : (r == 2) ? 2 : 3;
    endfunction

    function automatic void m_event(int r1, int r2);
        int rr[2];
        int good = 0, bad = 0, misses = 0, pts = 0;
        if (m_over) return;
        rr[0] = r1; rr[1] = r2;
        foreach (rr[i]) begin
            if (rr[i] == 1) begin pts += 100; good++; end
            if (rr[i] == 2) begin pts += 50;  good++; end
            if (rr[i] == 3) begin bad++; misses++; end
            if (rr[i] == 4) bad++;
        end
        m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
        m_combo = (bad > 0) ? 0 : ((m_combo + good > 255) ? 255 : m_combo + good);
        if (m_combo > m_max) m_max = m_combo;
        m_life = (m_life > misses) ? m_life - misses : 0;
        if (r1 != 0) m_j1 = m_code(r1);
        if (r2 != 0) m_j2 = m_code(r2);
        if (r1 == 1) e_p1++;
        if (r1 == 2) e_n1++;
        if (r2 == 1) e_p2++;
        if (r2 == 2) e_n2++;
        if (m_life == 0) m_over = 1;
    endfunction

    function automatic int m_res(bit b, bit h, bit p);
        return !b ? 0 : h ? 1 : p ? 2 : 4;
    endfunction

    function automatic logic [40:0] m_pack();
        return {16'(m_score), 8'(m_combo), 8'(m_max), 4'(m_life), 2'(m_j1), 2'(m_j2), m_over};
    endfunction

    task automatic align();
        @(negedge clk);
        while (cyc % 4 != 0) @(negedge clk);
    endtask

    task automatic press(input bit b1, input bit b2, input bit h1, input bit p1,
                         input bit h2, input bit p2, input int hold, output int unsigned rise);
        align();
        i_hit_t1 = h1; i_pre_hit_t1 = p1; i_hit_t2 = h2; i_pre_hit_t2 = p2;
        i_btn_t1 = b1; i_btn_t2 = b2;
        rise = cyc;
        repeat (hold) @(negedge clk);
        i_btn_t1 = 0; i_btn_t2 = 0;
        repeat (14) @(negedge clk);
        i_hit_t1 = 0; i_pre_hit_t1 = 0; i_hit_t2 = 0; i_pre_hit_t2 = 0;
    endtask

    task automatic pulse_miss(input bit m1, input bit m2);
        @(negedge clk);
        i_miss_t1 = m1; i_miss_t2 = m2;
        @(negedge clk);
        i_miss_t1 = 0; i_miss_t2 = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic restart();
        i_game_start = 0;
        repeat (3) @(negedge clk);
        i_game_start = 1;
        repeat (3) @(negedge clk);
        m_start();
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (4) @(negedge clk);
        m_start();
        n_cmp++;
        if (dut_v !== m_pack()) begin n_err++; $display("FAIL reset_state got=%h want=%h", dut_v, m_pack()); end
        n_cmp++;
        if ({o_clear_t1_perf, o_clear_t1_norm, o_clear_t2_perf, o_clear_t2_norm} !== 4'b0) begin
            n_err++; $display("FAIL reset_clears got=%b want=0000", {o_clear_t1_perf, o_clear_t1_norm, o_clear_t2_perf, o_clear_t2_norm});
        end
        rst = 1;
        @(negedge clk);
        i_game_start = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_debounce();
        int unsigned rise;
        press(1, 0, 1, 0, 0, 0, 4, rise);
        n_cmp++;
        if (dut_v !== m_pack() || n_p1 != e_p1) begin
            n_err++; $display("FAIL short_press got=%h/%0d want=%h/%0d", dut_v, n_p1, m_pack(), e_p1);
        end
        press(1, 0, 1, 0, 0, 0, 12, rise);
        m_event(1, 0);
        n_cmp++;
        if (dut_v !== m_pack()) begin n_err++; $display("FAIL held_press_state got=%h want=%h", dut_v, m_pack()); end
        n_cmp++;
        if (n_p1 != e_p1 || n_n1 != e_n1) begin
            n_err++; $display("FAIL held_press_clear got=%0d/%0d want=%0d/%0d", n_p1, n_n1, e_p1, e_n1);
        end
        lat = int'(last_p1_cyc - rise);
        if (lat < 2 || lat > 11) lat = 10;
    endtask

    task automatic test_normal_empty();
        int unsigned rise;
        press(0, 1, 0, 0, 0, 1, 12, rise);
        m_event(0, 2);
        n_cmp++;
        if (dut_v !== m_pack()) begin n_err++; $display("FAIL normal_state got=%h want=%h", dut_v, m_pack()); end
        n_cmp++;
        if (n_n2 != e_n2 || n_p2 != e_p2) begin n_err++; $display("FAIL normal_clear got=%0d/%0d want=%0d/%0d", n_n2, n_p2, e_n2, e_p2); end
        press(0, 1, 0, 0, 0, 0, 12, rise);
        m_event(0, 4);
        n_cmp++;
        if (dut_v !== m_pack()) begin n_err++; $display("FAIL empty_state got=%h want=%h", dut_v, m_pack()); end
        n_cmp++;
        if (n_n2 != e_n2 || n_p2 != e_p2) begin n_err++; $display("FAIL empty_clear got=%0d/%0d want=%0d/%0d", n_n2, n_p2, e_n2, e_p2); end
    endtask

    task automatic test_simultaneous();
        int unsigned rise;
        int both0;
        for (int i = 0; i < 3; i++) begin
            press(1, 0, 1, 0, 0, 0, 12, rise);
            m_event(1, 0);
        end
        n_cmp++;
        if (o_combo !== 8'd3) begin n_err++; $display("FAIL combo_pre got=%0d want=3", o_combo); end
        both0 = n_both;
        press(1, 1, 1, 0, 1, 0, 12, rise);
        m_event(1, 1);
        n_cmp++;
        if (dut_v !== m_pack()) begin n_err++; $display("FAIL simul_state got=%h want=%h", dut_v, m_pack()); end
        n_cmp++;
        if (n_both - both0 != 1) begin n_err++; $display("FAIL simul_both_pulse got=%0d want=1", n_both - both0); end
    endtask

    task automatic test_miss_press();
        int p1 = n_p1, q1 = n_n1;
        align();
        i_hit_t1 = 1; i_btn_t1 = 1;
        repeat (lat - 1) @(negedge clk);
        i_miss_t1 = 1;
        @(negedge clk);
        i_miss_t1 = 0;
        repeat (12 - lat) @(negedge clk);
        i_btn_t1 = 0;
        repeat (14) @(negedge clk);
        i_hit_t1 = 0;
        m_event(3, 0);
        n_cmp++;
        if (dut_v !== m_pack()) begin n_err++; $display("FAIL miss_press_state got=%h want=%h", dut_v, m_pack()); end
        n_cmp++;
        if (n_p1 != p1 || n_n1 != q1) begin n_err++; $display("FAIL miss_press_clear got=%0d/%0d want=%0d/%0d", n_p1, n_n1, p1, q1); end
    endtask

    task automatic test_random();
        int unsigned rise;
        bit b1, b2, h1, p1, h2, p2;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 4) == 0 && m_life > 2) begin
                b1 = 1'($urandom_range(0, 1));
                b2 = !b1 || 1'($urandom_range(0, 1));
                pulse_miss(b1, b2);
                m_event(b1 ? 3 : 0, b2 ? 3 : 0);
            end else begin
                b1 = 1'($urandom_range(0, 1));
                b2 = !b1 || 1'($urandom_range(0, 1));
                h1 = 1'($urandom_range(0, 1)); p1 = 1'($urandom_range(0, 1));
                h2 = 1'($urandom_range(0, 1)); p2 = 1'($urandom_range(0, 1));
                press(b1, b2, h1, p1, h2, p2, 12, rise);
                m_event(m_res(b1, h1, p1), m_res(b2, h2, p2));
            end
            n_cmp++;
            if (dut_v !== m_pack()) begin n_err++; $display("FAIL rand_state[%0d] got=%h want=%h", i, dut_v, m_pack()); end
            n_cmp++;
            if ({n_p1, n_n1, n_p2, n_n2} != {e_p1, e_n1, e_p2, e_n2}) begin
                n_err++; $display("FAIL rand_clears[%0d] got=%0d,%0d,%0d,%0d want=%0d,%0d,%0d,%0d", i, n_p1, n_n1, n_p2, n_n2, e_p1, e_n1, e_p2, e_n2);
            end
        end
    endtask

    task automatic test_reset_mid();
        int unsigned rise;
        restart();
        for (int i = 0; i < 3; i++) begin
            press(1, 0, 1, 0, 0, 0, 12, rise);
            m_event(1, 0);
        end
        press(0, 1, 0, 0, 0, 1, 12, rise);
        m_event(0, 2);
        n_cmp++;
        if (o_score !== 16'd350) begin n_err++; $display("FAIL mid_score_pre got=%0d want=350", o_score); end
        rst = 0;
        @(negedge clk);
        rst = 1;
        m_start();
        n_cmp++;
        if (dut_v !== m_pack()) begin n_err++; $display("FAIL mid_reset_state got=%h want=%h", dut_v, m_pack()); end
        n_cmp++;
        if ({o_clear_t1_perf, o_clear_t1_norm, o_clear_t2_perf, o_clear_t2_norm} !== 4'b0) begin
            n_err++; $display("FAIL mid_reset_clears got=%b want=0000", {o_clear_t1_perf, o_clear_t1_norm, o_clear_t2_perf, o_clear_t2_norm});
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_game_over();
        int unsigned rise;
        int p1;
        pulse_miss(1, 1); m_event(3, 3);
        pulse_miss(1, 1); m_event(3, 3);
        n_cmp++;
        if (o_life !== 4'd1) begin n_err++; $display("FAIL over_life1 got=%0d want=1", o_life); end
        @(negedge clk);
        i_miss_t1 = 1;
        @(negedge clk);
        i_miss_t1 = 0;
        m_event(3, 0);
        n_cmp++;
        if (o_life !== 4'd0 || o_game_over !== 1'b0) begin n_err++; $display("FAIL over_life0 got=%0d/%b want=0/0", o_life, o_game_over); end
        @(negedge clk);
        n_cmp++;
        if (o_game_over !== 1'b1) begin n_err++; $display("FAIL over_flag got=%b want=1", o_game_over); end
        p1 = n_p1;
        press(1, 0, 1, 0, 0, 0, 12, rise);
        pulse_miss(0, 1);
        m_event(1, 3);
        n_cmp++;
        if (dut_v !== m_pack() || n_p1 != p1) begin n_err++; $display("FAIL over_frozen got=%h/%0d want=%h/%0d", dut_v, n_p1, m_pack(), p1); end
        i_game_start = 0;
        @(negedge clk);
        n_cmp++;
        if (o_game_over !== 1'b0) begin n_err++; $display("FAIL over_to_idle got=%b want=0", o_game_over); end
        i_game_start = 1;
        @(negedge clk);
        m_start();
        n_cmp++;
        if (dut_v !== m_pack()) begin n_err++; $display("FAIL over_restart got=%h want=%h", dut_v, m_pack()); end
    endtask

    task automatic test_saturation();
        int unsigned rise;
        for (int i = 0; i < 330; i++) begin
            press(1, 1, 1, 0, 1, 0, 12, rise);
            m_event(1, 1);
        end
        n_cmp++;
        if (dut_v !== m_pack()) begin n_err++; $display("FAIL saturation got=%h want=%h", dut_v, m_pack()); end
        n_cmp++;
        if (o_score !== 16'hFFFF || o_combo !== 8'd255 || o_max_combo !== 8'd255) begin
            n_err++; $display("FAIL saturation_vals got=%h/%0d/%0d want=ffff/255/255", o_score, o_combo, o_max_combo);
        end
        n_cmp++;
        if (n_wide != 0) begin n_err++; $display("FAIL clear_width got=%0d want=0", n_wide); end
    endtask

    initial begin
        rst = 0; i_btn_t1 = 0; i_btn_t2 = 0; i_game_start = 0;
        i_hit_t1 = 0; i_pre_hit_t1 = 0; i_hit_t2 = 0; i_pre_hit_t2 = 0;
        i_miss_t1 = 0; i_miss_t2 = 0;
        m_start();
        test_reset();
        test_debounce();
        test_normal_empty();
        test_simultaneous();
        test_miss_press();
        test_random();
        test_reset_mid();
        test_game_over();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/judge_ctrl.md
Name: judge_ctrl

Overview:
- Judgement stage between the player buttons and lcd_ctrl.
- Consumes lcd_ctrl's hit, pre-hit and miss indications, and debounced button presses for each track.
- Decides Perfect, Normal, Empty or Miss for each track and sends one-cycle clear pulses back to lcd_ctrl.
- Keeps score, combo and life counts, and drives the game-over flag that lcd_ctrl uses to show its end screen.

Parameters:
- DEBOUNCE_MS, 10: number of consecutive 1 ms ticks a synchronised button level must hold before it is accepted.
- PERFECT_PTS, 100: score added for a Perfect hit.
- NORMAL_PTS, 50: score added for a Normal hit.
- LIFE_INIT, 5: lives loaded on game start (range 1..15).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk
- i_tick  in  1  1 ms strobe, one cycle wide
- i_btn_t1  in  1  raw Track 1 button, active-high, asynchronous
- i_btn_t2  in  1  raw Track 2 button, active-high, asynchronous
- i_game_start  in  1  level: 1 = play requested
- i_hit_t1, i_pre_hit_t1  in  1  note present in cell 0 / cell 1 of Track 1
- i_hit_t2, i_pre_hit_t2  in  1  same for Track 2
- i_miss_t1, i_miss_t2  in  1  one-cycle miss pulse from lcd_ctrl
- o_clear_t1_perf, o_clear_t1_norm, o_clear_t2_perf, o_clear_t2_norm  out  1  one-cycle clear pulses to lcd_ctrl
- o_judge_t1, o_judge_t2  out  2  last result for the track: 0 none, 1 Perfect, 2 Normal, 3 Miss/Empty
- o_score  out  16  accumulated score, saturating
- o_combo  out  8  current combo, saturating at 255
- o_max_combo  out  8  highest combo reached this game
- o_life  out  4  remaining lives
- o_game_over  out  1  level, 1 while in state OVER

Behaviour:
- Reset (rst=0 at a clk edge):
  - State is IDLE.
  - All outputs are 0, except o_life = LIFE_INIT.
  - Synchronisers, debounce counters and stable button levels are cleared to 0.
  - Reset asserted mid-game aborts the game immediately; no clear pulses are issued in that cycle.
- Button path, per track, independent of state:
  - Raw button passes through a 2-flop synchroniser giving the synchronised level.
  - If the synchronised level equals the stable level, the debounce count is 0.
  - Otherwise the count increments on each i_tick.
  - On the tick where the count reaches DEBOUNCE_MS, the stable level takes the synchronised level and the count returns to 0.
  - A press edge is the stable level rising 0->1, exactly one cycle wide.
  - A release produces no event.
  - Press edges are evaluated only in PLAY.
- State machine:
  - IDLE -> PLAY when i_game_start=1. On entry: score, combo, max_combo and judge outputs are cleared to 0, o_life = LIFE_INIT.
  - PLAY -> OVER in the cycle after o_life becomes 0.
  - PLAY -> IDLE if i_game_start=0; counters hold their values.
  - OVER: o_game_over=1; all counters frozen; presses and misses ignored. OVER -> IDLE when i_game_start=0.
- Judgement in PLAY, per track, evaluated in the cycle E where an event occurs (inputs sampled in cycle E):
  - Miss pulse: result is Miss. Any press in the same cycle on that track is absorbed; no clear pulse is issued.
  - Else press with hit=1: result is Perfect; the perf clear pulse is asserted in cycle E+1.
  - Else press with pre_hit=1 (hit=0): result is Normal; the norm clear pulse is asserted in cycle E+1.
  - Else press: result is Empty (o_judge code 3); no clear pulse.
  - Clear pulses last exactly one cycle.
  - o_judge_tN updates in E+1 and holds until the next event on that track.
- Counters, updated in E+1 from both tracks combined:
  - score += sum of points for the track results; saturates at 16'hFFFF.
  - If either track's result is Miss or Empty, combo = 0. Otherwise combo += number of Perfect/Normal results (0..2), saturating at 255.
  - max_combo = max(max_combo, new combo), updated in the same cycle.
  - life -= number of Miss results (0..2), saturating at 0.
  - Empty presses never cost a life.

Test Plan:
- Debounce: DEBOUNCE_MS=2. Button high for 1 tick then low -> no judge event. Button held for 3 ticks with i_hit_t1=1 -> exactly one o_clear_t1_perf pulse; score=100, combo=1, o_judge_t1=1.
- Normal and Empty presses: Track 2 press with pre_hit=1, hit=0 -> o_clear_t2_norm pulse, score +50. Next press with hit=0 and pre_hit=0 -> combo=0, o_judge_t2=3, no clear pulse, life unchanged.
- Simultaneous: both tracks Perfect in the same cycle from combo=3 -> combo=5, score +200, both perf clear pulses asserted in the same cycle.
- Miss with press: i_miss_t1 and a T1 press in the same cycle, LIFE_INIT=5 -> life=4, combo=0, no o_clear_t1_*.
- Game over: LIFE_INIT=2, two misses -> life=0 then o_game_over=1 the next cycle. Further presses change nothing. i_game_start=0 -> IDLE. i_game_start=1 -> score=0, life=2.
- Reset mid-play: rst=0 for one cycle with score=350 -> all outputs 0, o_life=LIFE_INIT, state IDLE.
- Saturation: score preloaded to near 16'hFFFF and a Perfect applied -> score = 16'hFFFF. 260 consecutive hits -> combo=255, max_combo=255.
